pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard-control block for the RV32IM pipeline. It tracks in-flight register writes behind ID in a DEPTH-entry scoreboard and resolves ID-stage RAW hazards with either a stall or a registered forwarding select. It also drives IF/ID/EX flush on a taken branch or jump and freezes with the shared BUSYWAIT. It sits beside the control unit and feeds the PC, IF/ID and ID/EX register enables and the EX operand muxes.

## Interface
- DEPTH, 3: scoreboard entries (stages after ID that can write the regfile: EX, MA, WB, …); legal range 2..8
- ADDR_W, 5: register address width
- FWD_W, $clog2(DEPTH+1): forwarding select width
- CLK in 1: clock, all state on rising edge
- RST in 1: reset, asynchronous, active-low
- BUSYWAIT in 1: memory stall; freezes all state
- RS1_ID in ADDR_W: rs1 of instruction in ID
- RS2_ID in ADDR_W: rs2 of instruction in ID
- RS1_USED_ID in 1: instruction in ID reads rs1
- RS2_USED_ID in 1: instruction in ID reads rs2
- WE_ID in 1: instruction in ID writes rd
- WADDR_ID in ADDR_W: rd of instruction in ID
- LOAD_ID in 1: instruction in ID is a load
- BRANCH_TAKEN_EX in 1: taken branch/jump resolved in EX (PC_MUX_SEL)
- STALL out 1: hold PC and IF/ID (combinational)
- BUBBLE out 1: load a NOP into ID/EX (combinational)
- FLUSH out 1: clear IF/ID and ID/EX (combinational, = BRANCH_TAKEN_EX)
- FWD_A_EX out FWD_W: operand-A source for instruction now in EX (registered)
- FWD_B_EX out FWD_W: operand-B source for instruction now in EX (registered)

## Operation
- Scoreboard entry k holds {valid, waddr, load}:
  - k=0 is the instruction in EX.
  - k=DEPTH-1 is the oldest stage.
- An instruction with WE_ID=0 or WADDR_ID=0 enters as valid=0; x0 is never tracked.
- A source matches entry k when all of these hold:
  - its USED bit is 1;
  - rs≠0;
  - entry k is valid;
  - entry k waddr equals rs.
- The youngest (lowest k) match wins.
- Hazard rule with forwarding:
  - A match on entry 0 with load=1 is a load-use hazard: STALL=1 and BUBBLE=1.
  - Any other match selects code k+1 for the instruction's EX cycle.
  - Code meaning: 0 = regfile, 1 = EX/MA register, 2 = MA/WB register, n = stage n result.
  - A match on entry DEPTH-1 (write occurring now) gives code DEPTH.
- Advance when BUSYWAIT=0:
  - entry k ← entry k-1 for all k≥1;
  - entry 0 ← ID instruction, or invalid if STALL or FLUSH;
  - FWD_*_EX ← computed selects, or 0 if STALL or FLUSH.
- When BUSYWAIT=1: entries and FWD registers hold; STALL, BUBBLE and FLUSH are still driven combinationally.
- FLUSH:
  - Kills only the ID instruction; the branch in entry 0 stays valid, so JAL/JALR rd is tracked.
  - FLUSH=1 forces STALL=0 and BUBBLE=0; flush has priority over stall.
- A stalled instruction re-evaluates each cycle. After one bubble the load sits in entry 1 and the consumer receives code 2.

## Timing
- Reset (RST low, asynchronous): all entries valid=0, FWD_A_EX=FWD_B_EX=0. STALL, BUBBLE and FLUSH are 0 whenever BRANCH_TAKEN_EX=0.
- STALL, BUBBLE and FLUSH follow their inputs in the same cycle, with zero latency.
- FWD_*_EX appears one edge after the consumer leaves ID, and is valid for its whole EX cycle.
- Load-use costs exactly 1 stall cycle. A non-load producer costs 0 cycles with forwarding.
- RST low mid-stall clears the scoreboard; first cycle after release has no hazards.
- BRANCH_TAKEN_EX together with a load-use match in the same cycle gives FLUSH=1, STALL=0, BUBBLE=0, and entry 0 ← invalid.
- Matches on both rs1 and rs2 are resolved independently; STALL is the OR of both.

## Configuration
- FORWARD_EN defined:
  - forwarding as above.
- FORWARD_EN undefined:
  - FWD_A_EX and FWD_B_EX are tied to 0.
  - Any match on entries 0..DEPTH-2 asserts STALL=1 and BUBBLE=1, load or not.
  - Entry DEPTH-1 is not a hazard; the regfile provides write-through.
  - A producer followed by a dependent instruction costs DEPTH-1 stall cycles.

## Test plan
- Reset, then add x3,x1,x2 followed by sub x4,x3,x5 (FORWARD_EN) -> STALL=0; FWD_A_EX=1 and FWD_B_EX=0 during sub's EX.
- lw x6,0(x1) followed by add x7,x6,x6 -> STALL=1 and BUBBLE=1 for exactly 1 cycle; then FWD_A_EX=FWD_B_EX=2.
- addi x0,x0,1 followed by add x8,x0,x0 -> no stall; FWD codes stay 0.
- Taken beq in EX while a dependent lw-use pair is in ID -> FLUSH=1, STALL=0; the killed instruction never appears in the scoreboard.
- BUSYWAIT=1 for 4 cycles mid-sequence -> entries and FWD registers unchanged; sequence resumes with identical codes once BUSYWAIT=0.
- FORWARD_EN undefined, DEPTH=3: add x3,… followed by use of x3 -> STALL=1 for 2 cycles; FWD stays 0; then proceeds.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: RAW hazard scoreboard with stall/flush control and optional forwarding (FORWARD_EN)
module pipe_hazard_unit #(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5,
  parameter int FWD_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busywait,
  input  logic [ADDR_W-1:0] rs1_id,
  input  logic [ADDR_W-1:0] rs2_id,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic              we_id,
  input  logic [ADDR_W-1:0] waddr_id,
  input  logic              load_id,
  input  logic              branch_taken_ex,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [FWD_W-1:0]  fwd_a_ex,
  output logic [FWD_W-1:0]  fwd_b_ex
);
  logic [DEPTH-1:0]  v;
  logic [ADDR_W-1:0] wa [DEPTH];
  logic [FWD_W-1:0]  code_a, code_b;
  logic              hazard, kill;
  // youngest matching entry per source, encoded as k+1 (0 = no match)
  always_comb begin
    code_a = '0;
    code_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs1_used_id && rs1_id != '0 && v[k] && wa[k] == rs1_id) code_a = FWD_W'(k + 1);
      if (rs2_used_id && rs2_id != '0 && v[k] && wa[k] == rs2_id) code_b = FWD_W'(k + 1);
    end
  end
  assign flush  = branch_taken_ex;
  assign stall  = hazard & ~branch_taken_ex;
  assign bubble = stall;
  assign kill   = stall | flush;
  // shift the in-flight writers one stage; a killed ID instruction enters as invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) wa[k] <= '0;
    end else if (!busywait) begin
      v     <= {v[DEPTH-2:0], we_id && waddr_id != '0 && !kill};
      wa[0] <= waddr_id;
      for (int k = 1; k < DEPTH; k++) wa[k] <= wa[k-1];
    end
  end
`ifdef FORWARD_EN
  logic ld0;
  assign hazard = ld0 && (code_a == FWD_W'(1) || code_b == FWD_W'(1));
  // only the EX-stage load flag matters: later loads have data ready to forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld0      <= 1'b0;
      fwd_a_ex <= '0;
      fwd_b_ex <= '0;
    end else if (!busywait) begin
      ld0      <= load_id && !kill;
      fwd_a_ex <= kill ? '0 : code_a;
      fwd_b_ex <= kill ? '0 : code_b;
    end
  end
`else
  logic unused_load;
  assign unused_load = load_id;
  assign hazard = (code_a != '0 && code_a < FWD_W'(DEPTH)) || (code_b != '0 && code_b < FWD_W'(DEPTH));
  assign fwd_a_ex = '0;
  assign fwd_b_ex = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: scoreboard bench for pipe_hazard_unit against an instruction-history model
module tb_pipe_hazard_unit;
  localparam int DEPTH = 3;
  localparam int FWD_W = $clog2(DEPTH + 1);

  logic clk = 0, rst_n = 0, busywait = 0;
  logic [4:0] rs1_id = 0, rs2_id = 0, waddr_id = 0;
  logic rs1_used_id = 0, rs2_used_id = 0, we_id = 0, load_id = 0, branch_taken_ex = 0;
  logic stall, bubble, flush;
  logic [FWD_W-1:0] fwd_a_ex, fwd_b_ex;

  pipe_hazard_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .busywait(busywait),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .we_id(we_id), .waddr_id(waddr_id), .load_id(load_id), .branch_taken_ex(branch_taken_ex),
    .stall(stall), .bubble(bubble), .flush(flush), .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; bit [4:0] rd; bit ld;} ent_t;
  typedef struct {bit st; bit bu; bit fl; int fa; int fb;} exp_t;

  ent_t hist[$];
  exp_t exp_q[$];
  int   m_fa, m_fb;
  bit   last_stall;
  int   checks = 0, failures = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", n, a, e, $time);
    end
  endfunction

  // history index of the most recent instruction (0 = now in EX) writing rs, -1 if none
  function automatic int find(bit used, bit [4:0] rs);
    if (!used || rs == 0) return -1;
    for (int i = 0; i < DEPTH; i++) if (hist[i].v && hist[i].rd == rs) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    hist = {};
    repeat (DEPTH) hist.push_back('{1'b0, 5'd0, 1'b0});
    m_fa = 0;
    m_fb = 0;
  endfunction

  task automatic step(input bit [4:0] r1, input bit [4:0] r2, input bit u1, input bit u2,
                      input bit we, input bit [4:0] rd, input bit ld, input bit br, input bit bw);
    int ia, ib;
    bit haz, st, kl;
    exp_t e;
    @(posedge clk);
    #1;
    rs1_id = r1; rs2_id = r2; rs1_used_id = u1; rs2_used_id = u2;
    we_id = we; waddr_id = rd; load_id = ld; branch_taken_ex = br; busywait = bw;
    ia = find(u1, r1);
    ib = find(u2, r2);
`ifdef FORWARD_EN
    haz = (ia == 0 || ib == 0) && hist[0].ld;
`else
    haz = (ia >= 0 && ia < DEPTH - 1) || (ib >= 0 && ib < DEPTH - 1);
`endif
    st = haz && !br;
    e = '{st, st, br, m_fa, m_fb};
    exp_q.push_back(e);
    if (!bw) begin
      kl = st || br;
      hist.push_front('{!kl && we && rd != 0, rd, ld});
      void'(hist.pop_back());
`ifdef FORWARD_EN
      m_fa = kl ? 0 : ia + 1;
      m_fb = kl ? 0 : ib + 1;
`endif
    end
    last_stall = st;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // present one instruction in ID, holding it there while it is stalled
  task automatic issue(input bit [4:0] r1, input bit [4:0] r2, input bit u1, input bit u2,
                       input bit we, input bit [4:0] rd, input bit ld);
    for (int n = 0; n < 8; n++) begin
      step(r1, r2, u1, u2, we, rd, ld, 0, 0);
      if (!last_stall) return;
    end
    chk("issue_stall_bound", 1, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", stall, e.st);
        chk("bubble", bubble, e.bu);
        chk("flush", flush, e.fl);
        chk("fwd_a", fwd_a_ex, e.fa);
        chk("fwd_b", fwd_b_ex, e.fb);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12 rst_n = 1;
    idle();
    issue(1, 2, 1, 1, 1, 3, 0);
    issue(3, 5, 1, 1, 1, 4, 0);
    idle(); idle(); idle();
    issue(1, 0, 1, 0, 1, 6, 1);
    issue(6, 6, 1, 1, 1, 7, 0);
    idle(); idle(); idle();
    issue(0, 0, 1, 0, 1, 0, 0);
    issue(0, 0, 1, 1, 1, 8, 0);
    idle(); idle(); idle();
    issue(1, 0, 1, 0, 1, 9, 1);
    step(9, 9, 1, 1, 1, 10, 0, 1, 0);
    issue(9, 10, 1, 1, 1, 11, 0);
    idle(); idle(); idle();
    issue(1, 2, 1, 1, 1, 3, 0);
    issue(3, 3, 1, 1, 1, 12, 0);
    repeat (4) step(12, 3, 1, 1, 1, 13, 0, 0, 1);
    issue(12, 3, 1, 1, 1, 13, 0);
    idle(); idle(); idle();
    issue(1, 0, 1, 0, 1, 14, 1);
    step(14, 0, 1, 0, 1, 15, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 0;
    model_reset();
    #1 rst_n = 1;
    issue(14, 0, 1, 0, 1, 15, 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 4), 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    repeat (2) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
